// File: rtl/verificar_ganador.sv
// Connect4 winner checker.
// Snapshots the board on start, then walks the anchor cells one per cycle in
// ascending f*COLUMNAS+c order, looking for four-in-a-row. It reports the
// first winning line found, or a draw when the board is full.
module verificar_ganador #(
   parameter int FILAS    = 6,
   parameter int COLUMNAS = 7,
   parameter int EN_LINEA = 4
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              enable,
   input  logic                              start,
   input  logic [FILAS-1:0][COLUMNAS-1:0]    tablero,
   input  logic [FILAS-1:0][COLUMNAS-1:0]    fichas,
   output logic                              busy,
   output logic                              done,
   output logic                              ganador,
   output logic                              jugador_ganador,
   output logic                              empate,
   output logic [FILAS-1:0][COLUMNAS-1:0]    linea
);

   localparam int N  = FILAS * COLUMNAS;
   localparam int IW = $clog2(N);
   localparam int FW = $clog2(FILAS);
   localparam int CW = $clog2(COLUMNAS);

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

   state_t         r_state, w_next;
   logic [N-1:0]   r_tab, r_fic;
   logic [FW-1:0]  r_f;
   logic [CW-1:0]  r_c;
   // Registered result of the previous anchor (one-stage evaluation pipe).
   logic           r_hv, r_hw, r_hj, r_hl;
   logic [N-1:0]   r_hm;
   logic           r_ganador, r_jug, r_empate;
   logic [N-1:0]   r_linea;

   logic           w_win, w_jug, w_last, w_fin;
   logic [N-1:0]   w_mask;
   logic [N+1:0]   w_res;

   // Evaluate one direction from anchor (f,c): 0=H, 1=V, 2=DR, 3=DL.
   // Returns {win, owner, mask}. Cells are only indexed once the whole
   // window is known to lie on the board.
   function automatic logic [N+1:0] eval_dir(input int d, input int f, input int c,
                                             input logic [N-1:0] tab,
                                             input logic [N-1:0] fic);
      int            df, dc, ef, ec;
      logic          ok, j;
      logic [N-1:0]  m;
      logic [IW-1:0] idx;
      df = (d == 0) ? 0 : 1;
      dc = (d == 1) ? 0 : ((d == 3) ? -1 : 1);
      ef = f + df * (EN_LINEA - 1);
      ec = c + dc * (EN_LINEA - 1);
      ok = (ef < FILAS) && (ec >= 0) && (ec < COLUMNAS);
      m  = '0;
      j  = 1'b0;
      if (ok) begin
         idx = IW'(f * COLUMNAS + c);
         j   = fic[idx];
         for (int i = 0; i < EN_LINEA; i++) begin
            idx = IW'((f + df * i) * COLUMNAS + c + dc * i);
            if (!tab[idx] || (fic[idx] != j)) ok = 1'b0;
            m[idx] = 1'b1;
         end
      end
      if (!ok) begin
         m = '0;
         j = 1'b0;
      end
      return {ok, j, m};
   endfunction

   // Check all four directions at the current anchor; H has highest priority,
   // so it is evaluated last and overrides the others.
   always_comb begin
      w_win  = 1'b0;
      w_jug  = 1'b0;
      w_mask = '0;
      w_res  = '0;
      for (int d = 3; d >= 0; d--) begin
         w_res = eval_dir(d, int'(r_f), int'(r_c), r_tab, r_fic);
         if (w_res[N+1]) begin
            w_win  = 1'b1;
            w_jug  = w_res[N];
            w_mask = w_res[N-1:0];
         end
      end
   end

   assign w_last = (r_f == FW'(FILAS - 1)) && (r_c == CW'(COLUMNAS - 1));
   // Scan ends once a registered anchor result is a win or was the last cell.
   assign w_fin  = r_hv && (r_hw || r_hl);

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Next-state logic; enable=0 holds the current state.
   always_comb begin
      w_next = r_state;
      if (enable) begin
         case (r_state)
            S_IDLE:  if (start) w_next = S_SCAN;
            S_SCAN:  if (w_fin) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
         endcase
      end
   end

   // Snapshot, anchor walk, evaluation pipe and held results.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_tab     <= '0;
         r_fic     <= '0;
         r_f       <= '0;
         r_c       <= '0;
         r_hv      <= 1'b0;
         r_hw      <= 1'b0;
         r_hj      <= 1'b0;
         r_hl      <= 1'b0;
         r_hm      <= '0;
         r_ganador <= 1'b0;
         r_jug     <= 1'b0;
         r_empate  <= 1'b0;
         r_linea   <= '0;
      end else if (enable) begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_tab     <= tablero;
                  r_fic     <= fichas;
                  r_f       <= '0;
                  r_c       <= '0;
                  r_hv      <= 1'b0;
                  r_ganador <= 1'b0;
                  r_jug     <= 1'b0;
                  r_empate  <= 1'b0;
                  r_linea   <= '0;
               end
            end
            S_SCAN: begin
               r_hv <= 1'b1;
               r_hw <= w_win;
               r_hj <= w_jug;
               r_hm <= w_mask;
               r_hl <= w_last;
               if (!w_last) begin
                  if (r_c == CW'(COLUMNAS - 1)) begin
                     r_c <= '0;
                     r_f <= r_f + 1'b1;
                  end else begin
                     r_c <= r_c + 1'b1;
                  end
               end
               if (w_fin) begin
                  r_ganador <= r_hw;
                  r_jug     <= r_hw & r_hj;
                  r_linea   <= r_hw ? r_hm : '0;
                  r_empate  <= !r_hw && (&r_tab);
               end
            end
            default: ;
         endcase
      end
   end

   assign busy            = (r_state != S_IDLE);
   assign done            = (r_state == S_DONE);
   assign ganador         = r_ganador;
   assign jugador_ganador = r_jug;
   assign empate          = r_empate;
   assign linea           = r_linea;

endmodule
